me_block_scheduler: RTL and testbench

- Sequencer for the full-search motion estimation core (`me_top`) across a frame of template blocks.
- Steps a NUM_BLK_X x NUM_BLK_Y block grid and drives block coordinates to the datapath.
- Runs one four-phase req/ack transaction with the ME core per block.
- Captures each block's min_sad/min_mvec into a small result FIFO, drained by a valid/ready consumer. Sits between the host/board control logic and `me_top`.

---
 rtl/me_sched_pkg.sv | 35 +++
 rtl/me_result_fifo.sv | 57 +++++
 rtl/me_block_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_me_block_scheduler.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_sched_pkg.sv
// Shared types and width constants for the motion-estimation block scheduler.
package me_sched_pkg;

  localparam int DEF_NUM_BLK_X = 4;
  localparam int DEF_NUM_BLK_Y = 4;
  localparam int DEF_CNT_WIDTH = $clog2((64 - 16 + 1) * (64 - 16 + 1));
  localparam int DEF_SAD_WIDTH = $clog2(16 * 16) + 8;

  // Result entry fields are sized for the largest supported configuration;
  // narrower builds zero-extend into them.
  localparam int MAX_BLK_W = 8;
  localparam int MAX_SAD_W = 32;
  localparam int MAX_CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAPTURE,
    S_RELEASE,
    S_NEXT,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic [MAX_BLK_W-1:0] blk;
    logic [MAX_SAD_W-1:0] sad;
    logic [MAX_CNT_W-1:0] mvec;
  } res_entry_t;

  // Index width that stays at least one bit for single-entry dimensions.
  function automatic int w1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/me_result_fifo.sv
// Synchronous result FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module me_result_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Head is forced to zero while empty so the consumer never sees stale storage.
  always_comb begin
    dout = '0;
    if (!empty) dout = mem[rd_ptr];
  end

endmodule

// File: rtl/me_block_scheduler.sv
// Frame sequencer for me_top: walks the block grid, runs one req/ack handshake per block, queues results.
// Optional watchdog enabled by defining ME_SCHED_TIMEOUT_EN.
module me_block_scheduler
  import me_sched_pkg::*;
#(
  parameter int NUM_BLK_X      = DEF_NUM_BLK_X,
  parameter int NUM_BLK_Y      = DEF_NUM_BLK_Y,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int SAD_WIDTH      = DEF_SAD_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  output logic                                busy,
  output logic                                done,
  output logic [w1(NUM_BLK_X)-1:0]            blk_x,
  output logic [w1(NUM_BLK_Y)-1:0]            blk_y,
  output logic                                me_req,
  input  logic                                me_ack,
  input  logic [SAD_WIDTH-1:0]                me_min_sad,
  input  logic [CNT_WIDTH-1:0]                me_min_mvec,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [SAD_WIDTH-1:0]                res_sad,
  output logic [CNT_WIDTH-1:0]                res_mvec,
  output logic [w1(NUM_BLK_X*NUM_BLK_Y)-1:0]  res_blk,
  output logic                                err_timeout
);

  localparam int BX_W   = w1(NUM_BLK_X);
  localparam int BY_W   = w1(NUM_BLK_Y);
  localparam int BIDX_W = w1(NUM_BLK_X * NUM_BLK_Y);

  state_t     state;
  logic       abort_pend;
  logic       abort_now;
  logic       last_blk;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  res_entry_t wr_entry;
  res_entry_t head;
  logic       unused_head_bits;

  assign abort_now = abort_pend | abort;
  assign last_blk  = (blk_x == BX_W'(NUM_BLK_X - 1)) && (blk_y == BY_W'(NUM_BLK_Y - 1));
  assign res_valid = !fifo_empty;
  assign pop       = res_valid && res_ready;
  // A full FIFO still accepts the capture when the consumer frees a slot this cycle.
  assign push      = (state == S_CAPTURE) && (!fifo_full || pop);

  always_comb begin
    wr_entry      = '0;
    wr_entry.blk  = MAX_BLK_W'(int'(blk_y) * NUM_BLK_X + int'(blk_x));
    wr_entry.sad  = MAX_SAD_W'(me_min_sad);
    wr_entry.mvec = MAX_CNT_W'(me_min_mvec);
  end

`ifdef ME_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_stay;
  logic             err_q;

  // True when the FSM remains in a watched state across this edge.
  assign tmo_stay    = ((state == S_REQ) && !me_ack && !abort_now) ||
                       ((state == S_RELEASE) && me_ack);
  assign err_timeout = err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      me_req     <= 1'b0;
      blk_x      <= '0;
      blk_y      <= '0;
      abort_pend <= 1'b0;
`ifdef ME_SCHED_TIMEOUT_EN
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (busy && abort) abort_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_REQ;
            busy       <= 1'b1;
            me_req     <= 1'b1;
            blk_x      <= '0;
            blk_y      <= '0;
            abort_pend <= 1'b0;
`ifdef ME_SCHED_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
          end
        end
        S_REQ: begin
          if (me_ack) begin
            state <= S_CAPTURE;
          end else if (abort_now) begin
            state  <= S_RELEASE;
            me_req <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (push) begin
            state  <= S_RELEASE;
            me_req <= 1'b0;
          end
        end
        S_RELEASE: begin
          if (!me_ack) begin
            if (last_blk || abort_now) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (blk_x == BX_W'(NUM_BLK_X - 1)) begin
            blk_x <= '0;
            blk_y <= blk_y + BY_W'(1);
          end else begin
            blk_x <= blk_x + BX_W'(1);
          end
          state  <= S_REQ;
          me_req <= 1'b1;
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
`ifdef ME_SCHED_TIMEOUT_EN
      // Watchdog overrides the normal transition once a watched state overstays.
      if (tmo_stay) begin
        if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_q   <= 1'b1;
          me_req  <= 1'b0;
          state   <= S_FINISH;
          done    <= 1'b1;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end
`endif
    end
  end

  me_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (res_entry_t)
  ) u_result_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (wr_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Upper entry bits beyond this configuration's widths are always zero.
  assign unused_head_bits = ^head;
  assign res_blk  = head.blk[BIDX_W-1:0];
  assign res_sad  = head.sad[SAD_WIDTH-1:0];
  assign res_mvec = head.mvec[CNT_WIDTH-1:0];

endmodule

// File: tb/tb_me_block_scheduler.sv
// Self-checking bench for me_block_scheduler on a 2x2 grid with a 2-entry result FIFO.
module tb_me_block_scheduler;

  localparam int NX = 2;
  localparam int NY = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [0:0]  blk_x;
  logic [0:0]  blk_y;
  logic        me_req;
  logic        me_ack;
  logic [15:0] me_min_sad;
  logic [11:0] me_min_mvec;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_sad;
  logic [11:0] res_mvec;
  logic [1:0]  res_blk;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;
  int sb_errors = 0;
  int sb_checks = 0;

  logic me_en;
  int   me_dly;
  int   me_cnt;
  int   frame_tag;

  typedef struct {
    logic [1:0]  blk;
    logic [15:0] sad;
    logic [11:0] mvec;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;

  me_block_scheduler #(
    .NUM_BLK_X      (NX),
    .NUM_BLK_Y      (NY),
    .CNT_WIDTH      (12),
    .SAD_WIDTH      (16),
    .FIFO_DEPTH     (2),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .blk_x       (blk_x),
    .blk_y       (blk_y),
    .me_req      (me_req),
    .me_ack      (me_ack),
    .me_min_sad  (me_min_sad),
    .me_min_mvec (me_min_mvec),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sad     (res_sad),
    .res_mvec    (res_mvec),
    .res_blk     (res_blk),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] f_sad(input int idx, input int tag);
    return 16'(32'h1000 + tag * 256 + idx * 17 + 3);
  endfunction

  function automatic logic [11:0] f_mvec(input int idx, input int tag);
    return 12'(tag * 97 + idx * 311 + 5);
  endfunction

  // ME core model: acks me_dly cycles after req, holds ack until req falls.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      me_ack <= 1'b0;
      me_cnt <= 0;
    end else if (!me_req) begin
      me_ack <= 1'b0;
      me_cnt <= 0;
    end else if (me_en && !me_ack) begin
      if (me_cnt >= me_dly - 1) me_ack <= 1'b1;
      else me_cnt <= me_cnt + 1;
    end
  end

  assign me_min_sad  = f_sad(int'(blk_y) * NX + int'(blk_x), frame_tag);
  assign me_min_mvec = f_mvec(int'(blk_y) * NX + int'(blk_x), frame_tag);

  // Scoreboard: every accepted result must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      sb_checks++;
      if (exp_q.size() == 0) begin
        sb_errors++;
        $display("FAIL sb_unexpected: got blk=%0d sad=%h mvec=%h, required no result", res_blk, res_sad, res_mvec);
      end else begin
        sb_e = exp_q.pop_front();
        if (res_blk !== sb_e.blk || res_sad !== sb_e.sad || res_mvec !== sb_e.mvec) begin
          sb_errors++;
          $display("FAIL sb_result: got blk=%0d sad=%h mvec=%h, required blk=%0d sad=%h mvec=%h",
                   res_blk, res_sad, res_mvec, sb_e.blk, sb_e.sad, sb_e.mvec);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int first, input int count, input int tag);
    exp_t e;
    for (int i = first; i < first + count; i++) begin
      e.blk  = 2'(i);
      e.sad  = f_sad(i, tag);
      e.mvec = f_mvec(i, tag);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    cyc(3);
    checks++;
    if ({busy, done, me_req, res_valid, err_timeout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/req/valid/err=%b, required 00000", {busy, done, me_req, res_valid, err_timeout});
    end
    checks++;
    if ({blk_x, blk_y} !== 2'b0) begin
      errors++;
      $display("FAIL reset_coord: blk_x=%0d blk_y=%0d, required 0 0", blk_x, blk_y);
    end
    checks++;
    if ({res_blk, res_sad, res_mvec} !== 30'b0) begin
      errors++;
      $display("FAIL reset_res: blk=%0d sad=%h mvec=%h, required zeros", res_blk, res_sad, res_mvec);
    end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_frame();
    int n;
    frame_tag = 1;
    res_ready = 1'b1;
    push_exp(0, 4, 1);
    pulse_start();
    checks++;
    if (busy !== 1'b1 || me_req !== 1'b1 || blk_x !== 1'b0 || blk_y !== 1'b0) begin
      errors++;
      $display("FAIL frame_start: busy=%b req=%b x=%0d y=%0d, required 1 1 0 0", busy, me_req, blk_x, blk_y);
    end
    wait_done(400, n);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL frame_done: done=%b busy=%b after %0d cycles, required 1 1", done, busy, n);
    end
    cyc(1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_after_done: done=%b busy=%b, required 0 0", done, busy);
    end
    cyc(8);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_drain: done=%b busy=%b pending=%0d valid=%b, required 0 0 0 0", done, busy, exp_q.size(), res_valid);
    end
  endtask

  task automatic test_stall();
    int n;
    frame_tag = 2;
    res_ready = 1'b0;
    push_exp(0, 4, 2);
    pulse_start();
    n = 0;
    while (!(blk_y === 1'b1 && blk_x === 1'b0 && me_ack === 1'b1) && n < 300) begin
      cyc(1);
      n++;
    end
    cyc(20);
    checks++;
    if (me_req !== 1'b1 || busy !== 1'b1 || blk_y !== 1'b1 || blk_x !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: req=%b busy=%b x=%0d y=%0d, required 1 1 0 1", me_req, busy, blk_x, blk_y);
    end
    checks++;
    if (res_valid !== 1'b1 || res_blk !== 2'd0 || exp_q.size() != 4) begin
      errors++;
      $display("FAIL stall_fifo: valid=%b head=%0d pending=%0d, required 1 0 4", res_valid, res_blk, exp_q.size());
    end
    res_ready = 1'b1;
    wait_done(400, n);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: done=%b after %0d cycles, required 1", done, n);
    end
    cyc(4);
    checks++;
    if (exp_q.size() != 0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: pending=%0d valid=%b, required 0 0", exp_q.size(), res_valid);
    end
  endtask

  task automatic test_abort();
    int n;
    frame_tag = 3;
    res_ready = 1'b1;
    push_exp(0, 1, 3);
    pulse_start();
    n = 0;
    while (!(blk_x === 1'b1 && me_req === 1'b1) && n < 300) begin
      cyc(1);
      n++;
    end
    cyc(2);
    checks++;
    if (blk_x !== 1'b1 || me_req !== 1'b1 || me_ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_setup: x=%0d req=%b ack=%b, required 1 1 0", blk_x, me_req, me_ack);
    end
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    checks++;
    if (me_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_req_drop: req=%b, required 0", me_req);
    end
    wait_done(50, n);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL abort_done: done=%b after %0d cycles, required 1", done, n);
    end
    cyc(1);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b done=%b, required 0 0", busy, done);
    end
    cyc(20);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0 || me_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_result: pending=%0d busy=%b req=%b, required 0 0 0", exp_q.size(), busy, me_req);
    end
  endtask

  task automatic test_async_reset();
    int n;
    frame_tag = 4;
    res_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!(blk_x === 1'b1 && me_req === 1'b1) && n < 300) begin
      cyc(1);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (me_req !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || blk_x !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: req=%b busy=%b valid=%b x=%0d, required 0 0 0 0", me_req, busy, res_valid, blk_x);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    frame_tag = 5;
    res_ready = 1'b1;
    push_exp(0, 4, 5);
    pulse_start();
    checks++;
    if (me_req !== 1'b1 || blk_x !== 1'b0 || blk_y !== 1'b0) begin
      errors++;
      $display("FAIL restart_coord: req=%b x=%0d y=%0d, required 1 0 0", me_req, blk_x, blk_y);
    end
    wait_done(400, n);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL restart_done: done=%b after %0d cycles, required 1", done, n);
    end
    cyc(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_start_held();
    int n;
    frame_tag = 6;
    res_ready = 1'b1;
    push_exp(0, 4, 6);
    push_exp(0, 4, 6);
    start = 1'b1;
    cyc(1);
    wait_done(400, n);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL held_first_done: done=%b busy=%b after %0d cycles, required 1 1", done, busy, n);
    end
    cyc(1);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 4) begin
      errors++;
      $display("FAIL held_idle: busy=%b pending=%0d, required 0 4", busy, exp_q.size());
    end
    cyc(1);
    checks++;
    if (busy !== 1'b1 || me_req !== 1'b1) begin
      errors++;
      $display("FAIL held_second_start: busy=%b req=%b, required 1 1", busy, me_req);
    end
    start = 1'b0;
    wait_done(400, n);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL held_second_done: done=%b after %0d cycles, required 1", done, n);
    end
    cyc(12);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL held_end: busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err_timeout=%b, required 0", err_timeout);
    end
  endtask

`ifdef ME_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    me_en = 1'b0;
    pulse_start();
    n = 1;
    while (err_timeout !== 1'b1 && n < 300) begin
      cyc(1);
      n++;
    end
    checks++;
    if (err_timeout !== 1'b1 || n - 1 != 100) begin
      errors++;
      $display("FAIL timeout_cycle: err=%b after %0d REQ cycles, required 1 after 100", err_timeout, n - 1);
    end
    checks++;
    if (done !== 1'b1 || me_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_finish: done=%b req=%b, required 1 0", done, me_req);
    end
    cyc(2);
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: err=%b busy=%b, required 1 0", err_timeout, busy);
    end
    me_en = 1'b1;
    frame_tag = 7;
    push_exp(0, 4, 7);
    pulse_start();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: err=%b, required 0", err_timeout);
    end
    wait_done(400, n);
    cyc(4);
    checks++;
    if (exp_q.size() != 0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: pending=%0d err=%b, required 0 0", exp_q.size(), err_timeout);
    end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    res_ready = 1'b0;
    me_en     = 1'b1;
    me_dly    = 10;
    frame_tag = 0;
    test_reset();
    test_frame();
    test_stall();
    test_abort();
    test_async_reset();
    test_start_held();
`ifdef ME_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    cyc(4);
    errors = errors + sb_errors;
    checks = checks + sb_checks;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
